// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_cpu_pkg : shared register-file types and architectural register indices
// Revision 1.0
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_cpu_reg_scoreboard : per-register pending-write bits with busy lookup
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_cpu_reg_scoreboard
  import mips_cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic                   flush,
  input  logic [NUM_READ*AW-1:0] rd_addr,
  output logic [NUM_READ-1:0]    rd_busy,
  output logic                   any_pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                rsv_ok;

  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == AW'(REG_ZERO)));

  // Reservation is applied after the writeback clear: a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wr_en)  pending_d[wr_addr]  = 1'b0;
      if (rsv_ok) pending_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr       = rd_addr[k*AW +: AW];
    assign rd_busy[k] = pending_q[addr] & ~(wr_en && (wr_addr == addr));
  end

  assign any_pending = |pending_q;

endmodule : mips_cpu_reg_scoreboard
`default_nettype wire

// File: rtl/mips_cpu_regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_cpu_regfile_mp : multi-port register file with write bypass and scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_cpu_regfile_mp
  import mips_cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]     rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  input  logic                       flush,
  output logic                       any_pending,
  output logic [DATA_W-1:0]          register_v0
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_ok;

  // Gated by reset_n so the bypass cannot leak wr_data while reset is held.
  assign wr_ok = wr_en && reset_n &&
                 !((ZERO_REG != 0) && (wr_addr == AW'(REG_ZERO)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];
    assign rd_data[k*DATA_W +: DATA_W] = (wr_ok && (wr_addr == addr)) ? wr_data : regs_q[addr];
  end

  assign register_v0 = (wr_ok && (wr_addr == AW'(REG_V0))) ? wr_data : regs_q[AW'(REG_V0)];

  mips_cpu_reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_READ (NUM_READ),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .any_pending (any_pending)
  );

endmodule : mips_cpu_regfile_mp
`default_nettype wire

// File: tb/tb_mips_cpu_regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_cpu_regfile_mp : queue-based checker for default and 16b/8x4 configs
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mips_cpu_regfile_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // default configuration
  logic        a_wr_en = 0, a_rsv_en = 0, a_flush = 0;
  logic [4:0]  a_wr_addr = 0, a_rsv_addr = 0;
  logic [31:0] a_wr_data = 0;
  logic [9:0]  a_rd_addr = 0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_any;
  logic [31:0] a_v0;

  // 16-bit, 8 registers, 4 read ports, writable r0
  logic        b_wr_en = 0, b_rsv_en = 0, b_flush = 0;
  logic [2:0]  b_wr_addr = 0, b_rsv_addr = 0;
  logic [15:0] b_wr_data = 0;
  logic [11:0] b_rd_addr = 0;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_any;
  logic [15:0] b_v0;

  mips_cpu_regfile_mp u_dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .flush(a_flush), .any_pending(a_any), .register_v0(a_v0)
  );

  mips_cpu_regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_READ(4), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .flush(b_flush), .any_pending(b_any), .register_v0(b_v0)
  );

  localparam int S_A_RD0 = 0, S_A_RD1 = 1, S_A_BUSY = 2, S_A_ANY = 3, S_A_V0 = 4;
  localparam int S_B_RD = 5, S_B_BUSY = 6, S_B_ANY = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  logic  chk_req = 1'b0;

  function automatic logic [63:0] actual(int sig);
    case (sig)
      S_A_RD0:  return {32'h0, a_rd_data[31:0]};
      S_A_RD1:  return {32'h0, a_rd_data[63:32]};
      S_A_BUSY: return {62'h0, a_rd_busy};
      S_A_ANY:  return {63'h0, a_any};
      S_A_V0:   return {32'h0, a_v0};
      S_B_RD:   return b_rd_data;
      S_B_BUSY: return {60'h0, b_rd_busy};
      S_B_ANY:  return {63'h0, b_any};
      default:  return 64'hx;
    endcase
  endfunction

  // Monitor: drains the expectation queue whenever a sample is presented.
  initial begin
    forever begin
      wait (chk_req);
      while (q.size() > 0) begin
        item_t it;
        logic [63:0] act;
        it  = q.pop_front();
        act = actual(it.sig);
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
      chk_req = 1'b0;
    end
  end

  task automatic push(string n, int s, logic [63:0] e);
    q.push_back('{n, s, e});
  endtask

  task automatic sample();
    chk_req = 1'b1;
    fork
      wait (!chk_req);
      #3;
    join_any
    disable fork;
    if (chk_req) begin
      errors++;
      checks++;
      $display("FAIL monitor_timeout: got pending expected drained");
      chk_req = 1'b0;
      q.delete();
    end
  endtask

  task automatic idle();
    a_wr_en = 0; a_rsv_en = 0; a_flush = 0;
    b_wr_en = 0; b_rsv_en = 0; b_flush = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk); #1;
    push("rst_a_rd0", S_A_RD0, 0); push("rst_a_rd1", S_A_RD1, 0);
    push("rst_a_busy", S_A_BUSY, 0); push("rst_a_any", S_A_ANY, 0);
    push("rst_a_v0", S_A_V0, 0); push("rst_b_rd", S_B_RD, 0);
    push("rst_b_any", S_B_ANY, 0);
    sample();
    @(negedge clk); reset_n = 1'b1;

    // Test 1: reset pulse between edges, then r0 write is dropped
    @(negedge clk); #1 reset_n = 1'b0; #1 reset_n = 1'b1;
    @(negedge clk);
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hDEADBEEF;
    a_rsv_en = 1; a_rsv_addr = 0; a_rd_addr = {5'd0, 5'd0}; #1;
    push("t1_r0_byp_p0", S_A_RD0, 0); push("t1_r0_byp_p1", S_A_RD1, 0);
    push("t1_r0_busy", S_A_BUSY, 0); push("t1_v0", S_A_V0, 0);
    sample();
    @(negedge clk); idle(); #1;
    push("t1_r0_after_p0", S_A_RD0, 0); push("t1_r0_after_busy", S_A_BUSY, 0);
    push("t1_r0_after_any", S_A_ANY, 0);
    sample();
    @(negedge clk);
    a_wr_en = 1; a_wr_addr = 2; a_wr_data = 32'h11; #1;
    push("t1_v0_bypass", S_A_V0, 32'h11);
    sample();

    // Test 2: same-cycle write bypass
    @(negedge clk); a_wr_addr = 6; a_wr_data = 32'hCAFE;
    @(negedge clk);
    a_wr_addr = 5; a_wr_data = 32'h12345678; a_rd_addr = {5'd6, 5'd5}; #1;
    push("t2_bypass_p0", S_A_RD0, 32'h12345678); push("t2_old_p1", S_A_RD1, 32'hCAFE);
    push("t2_v0_reg", S_A_V0, 32'h11);
    sample();
    @(negedge clk); idle(); #1;
    push("t2_stored_p0", S_A_RD0, 32'h12345678);
    sample();

    // Test 3: reserve then writeback
    @(negedge clk); a_rsv_en = 1; a_rsv_addr = 8; a_rd_addr = {5'd8, 5'd8}; #1;
    push("t3_rsv_not_visible", S_A_BUSY, 0); push("t3_any_before", S_A_ANY, 0);
    sample();
    @(negedge clk); idle(); #1;
    push("t3_busy", S_A_BUSY, 2'b11); push("t3_any", S_A_ANY, 1);
    sample();
    @(negedge clk); a_wr_en = 1; a_wr_addr = 8; a_wr_data = 32'hA5A5A5A5; #1;
    push("t3_wb_busy", S_A_BUSY, 0); push("t3_wb_data", S_A_RD1, 32'hA5A5A5A5);
    push("t3_wb_any_reg", S_A_ANY, 1);
    sample();
    @(negedge clk); idle(); #1;
    push("t3_any_cleared", S_A_ANY, 0); push("t3_busy_cleared", S_A_BUSY, 0);
    sample();

    // Test 4: write+reserve same register, then flush with reserve
    @(negedge clk); a_rsv_en = 1; a_rsv_addr = 9; a_rd_addr = {5'd9, 5'd9};
    @(negedge clk); a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h1; #1;
    push("t4_wr_rsv_busy", S_A_BUSY, 0); push("t4_wr_rsv_data", S_A_RD0, 32'h1);
    sample();
    @(negedge clk); idle(); #1;
    push("t4_still_busy", S_A_BUSY, 2'b11); push("t4_data", S_A_RD0, 32'h1);
    push("t4_any", S_A_ANY, 1);
    sample();
    @(negedge clk); a_flush = 1; a_rsv_en = 1; a_rsv_addr = 10; a_rd_addr = {5'd10, 5'd9}; #1;
    push("t4_flush_cycle_busy", S_A_BUSY, 2'b01);
    sample();
    @(negedge clk); idle(); #1;
    push("t4_flushed_busy", S_A_BUSY, 0); push("t4_flushed_any", S_A_ANY, 0);
    sample();

    // Test 5: asynchronous reset mid-operation
    @(negedge clk); a_rsv_en = 1; a_rsv_addr = 3;
    @(negedge clk); a_rsv_addr = 4;
    @(negedge clk); a_rsv_en = 0; a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h77;
    a_rd_addr = {5'd4, 5'd3}; #1;
    push("t5_wb_busy", S_A_BUSY, 2'b10); push("t5_wb_data", S_A_RD0, 32'h77);
    sample();
    @(negedge clk); idle(); #1;
    push("t5_busy", S_A_BUSY, 2'b10); push("t5_data", S_A_RD0, 32'h77);
    push("t5_any", S_A_ANY, 1);
    sample();
    @(negedge clk);
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h99; a_rsv_en = 1; a_rsv_addr = 5;
    #1 reset_n = 1'b0; #1;
    push("t5_rst_data", S_A_RD0, 0); push("t5_rst_busy", S_A_BUSY, 0);
    push("t5_rst_any", S_A_ANY, 0); push("t5_rst_v0", S_A_V0, 0);
    sample();
    @(negedge clk); #1;
    push("t5_rst_held_data", S_A_RD0, 0); push("t5_rst_held_any", S_A_ANY, 0);
    sample();
    idle();
    @(negedge clk); reset_n = 1'b1;

    // Test 6: alternate configuration
    @(negedge clk); b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'hBEEF; b_rd_addr = '0; #1;
    push("t6_r0_bypass", S_B_RD, {4{16'hBEEF}});
    sample();
    @(negedge clk); idle(); #1;
    push("t6_r0_stored", S_B_RD, {4{16'hBEEF}}); push("t6_any0", S_B_ANY, 0);
    sample();
    @(negedge clk); b_rsv_en = 1; b_rsv_addr = 7; b_rd_addr = {4{3'd7}}; #1;
    push("t6_rsv_not_visible", S_B_BUSY, 0);
    sample();
    @(negedge clk); idle(); #1;
    push("t6_busy", S_B_BUSY, 4'hF); push("t6_any", S_B_ANY, 1);
    sample();
    @(negedge clk); b_wr_en = 1; b_wr_addr = 7; b_wr_data = 16'h1234;
    b_rd_addr = {3'd7, 3'd0, 3'd7, 3'd0}; #1;
    push("t6_wb_busy", S_B_BUSY, 0);
    push("t6_wb_data", S_B_RD, {16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF});
    sample();
    @(negedge clk); idle(); #1;
    push("t6_any_cleared", S_B_ANY, 0); push("t6_busy_cleared", S_B_BUSY, 0);
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips_cpu_regfile_mp
`default_nettype wire
